// File: rtl/q_channel_pwr_ctrl.sv
// q_channel_pwr_ctrl
//   Power controller for NUM_CH Q-channel low-power channels that share one
//   clock gate. After IDLE_CYCLES consecutive all-idle cycles, or on a
//   software request, it lowers every qreqn and waits for all qacceptn. It
//   then gates the channel clock. A wakeup (wake_i, a pending wake, or any
//   qactive) ungates the clock and completes the exit handshake.
//
// Ports
//   clk            in   1       single clock for the block
//   reset          in   1       asynchronous active-high reset
//   wake_i         in   1       wakeup request (level)
//   sw_sleep_req_i in   1       software sleep request (level, sampled in RUN)
//   qactive_i      in   NUM_CH  per-channel qactive
//   qacceptn_i     in   NUM_CH  per-channel qacceptn
//   qreqn_o        out  NUM_CH  per-channel qreqn, all bits equal
//   clk_en_o       out  1       channel clock-gate enable
//   pwr_state_o    out  2       0=RUN 1=REQ 2=STOPPED 3=EXIT
//   sleep_done_o   out  1       1-cycle pulse on entry to STOPPED
//   wake_done_o    out  1       1-cycle pulse on EXIT->RUN
module q_channel_pwr_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wake_i,
  input  logic              sw_sleep_req_i,
  input  logic [NUM_CH-1:0] qactive_i,
  input  logic [NUM_CH-1:0] qacceptn_i,
  output logic [NUM_CH-1:0] qreqn_o,
  output logic              clk_en_o,
  output logic [1:0]        pwr_state_o,
  output logic              sleep_done_o,
  output logic              wake_done_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REQ     = 2'd1,
    STOPPED = 2'd2,
    EXIT    = 2'd3
  } pwr_state_t;

  localparam int              IDLE_LAST_I = (IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1;
  localparam logic [CNT_W-1:0] IDLE_MAX   = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_LAST_I);
  localparam logic             AUTO_EN    = (IDLE_CYCLES != 0);

  pwr_state_t       state;
  pwr_state_t       next_state;
  logic [CNT_W-1:0] idle_cnt;
  logic             wake_pend;

  logic any_act;
  logic all_acc;
  logic all_rel;
  logic idle_hit;

  assign any_act  = |qactive_i;
  assign all_acc  = &(~qacceptn_i);
  assign all_rel  = &qacceptn_i;
  // The IDLE_CYCLES-th consecutive idle cycle is the one where the counter
  // already holds IDLE_CYCLES-1 and this cycle is idle as well.
  assign idle_hit = AUTO_EN && !any_act && (idle_cnt == IDLE_LAST);

  // State register plus the small amount of state that lives beside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      idle_cnt     <= '0;
      wake_pend    <= 1'b0;
      sleep_done_o <= 1'b0;
      wake_done_o  <= 1'b0;
    end else begin
      state <= next_state;

      if (state == RUN && next_state == RUN) begin
        if (wake_i || any_act)
          idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)
          idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      if (state == REQ && wake_i)
        wake_pend <= 1'b1;
      else if (state == STOPPED && next_state == EXIT)
        wake_pend <= 1'b0;

      sleep_done_o <= (state != STOPPED) && (next_state == STOPPED);
      wake_done_o  <= (state == EXIT) && (next_state == RUN);
    end
  end

  // Next-state logic. wake_i blocks both sleep causes; REQ cannot be aborted.
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (!wake_i && (sw_sleep_req_i || idle_hit)) next_state = REQ;
      REQ:     if (all_acc) next_state = STOPPED;
      STOPPED: if (wake_i || wake_pend || any_act) next_state = EXIT;
      EXIT:    if (all_rel) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    qreqn_o     = '1;
    clk_en_o    = 1'b1;
    pwr_state_o = state;
    case (state)
      REQ:     qreqn_o = '0;
      STOPPED: begin
        qreqn_o  = '0;
        clk_en_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_q_channel_pwr_ctrl.sv
module tb_q_channel_pwr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wake_i;
  logic       sw_sleep_req_i;
  logic [1:0] qactive_i;
  logic [1:0] qacceptn_i;
  logic [1:0] qreqn_o;
  logic       clk_en_o;
  logic [1:0] pwr_state_o;
  logic       sleep_done_o;
  logic       wake_done_o;

  int checks = 0;
  int errors = 0;

  q_channel_pwr_ctrl #(
    .NUM_CH(2),
    .IDLE_CYCLES(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wake_i(wake_i),
    .sw_sleep_req_i(sw_sleep_req_i),
    .qactive_i(qactive_i),
    .qacceptn_i(qacceptn_i),
    .qreqn_o(qreqn_o),
    .clk_en_o(clk_en_o),
    .pwr_state_o(pwr_state_o),
    .sleep_done_o(sleep_done_o),
    .wake_done_o(wake_done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // state, qreqn, clk_en, sleep_done, wake_done
  task automatic chk(input string tag, input logic [1:0] st, input logic [1:0] qr,
                     input logic ce, input logic sd, input logic wd);
    check({tag, ".state"}, {6'd0, pwr_state_o}, {6'd0, st});
    check({tag, ".qreqn"}, {6'd0, qreqn_o}, {6'd0, qr});
    check({tag, ".clk_en"}, {7'd0, clk_en_o}, {7'd0, ce});
    check({tag, ".sleep_done"}, {7'd0, sleep_done_o}, {7'd0, sd});
    check({tag, ".wake_done"}, {7'd0, wake_done_o}, {7'd0, wd});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    wake_i         = 1'b0;
    sw_sleep_req_i = 1'b0;
    qactive_i      = 2'b00;
    qacceptn_i     = 2'b11;
    #2;
    chk("reset", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;

    // 1: auto sleep after 4 idle cycles
    step(); chk("t1.idle1", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
    step(); chk("t1.idle2", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
    step(); chk("t1.idle3", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
    step(); chk("t1.req",   2'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    qacceptn_i = 2'b00;
    step(); chk("t1.stop",  2'd2, 2'b00, 1'b0, 1'b1, 1'b0);
    step(); chk("t1.stay",  2'd2, 2'b00, 1'b0, 1'b0, 1'b0);
    wake_i = 1'b1;
    step(); chk("t1.exit",  2'd3, 2'b11, 1'b1, 1'b0, 1'b0);
    wake_i = 1'b0;
    step(); chk("t1.exitw", 2'd3, 2'b11, 1'b1, 1'b0, 1'b0);
    qacceptn_i = 2'b11;
    step(); chk("t1.run",   2'd0, 2'b11, 1'b1, 1'b0, 1'b1);

    // 2: activity every 3 cycles keeps the idle counter below the threshold
    for (int r = 0; r < 3; r++) begin
      qactive_i = 2'b01;
      for (int k = 0; k < 3; k++) begin
        step(); chk("t2.act", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
      end
      qactive_i = 2'b00;
      for (int k = 0; k < 3; k++) begin
        step(); chk("t2.idle", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
      end
    end

    // 3: software sleep with active channels, partial accept holds REQ
    sw_sleep_req_i = 1'b1;
    qactive_i      = 2'b11;
    step(); chk("t3.req", 2'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    sw_sleep_req_i = 1'b0;
    qacceptn_i     = 2'b10;
    for (int k = 0; k < 10; k++) begin
      step(); chk("t3.partial", 2'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    end

    // 4: wake pulse during REQ is remembered
    wake_i = 1'b1;
    step(); chk("t4.wake_in_req", 2'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    wake_i     = 1'b0;
    qactive_i  = 2'b00;
    qacceptn_i = 2'b00;
    step(); chk("t4.stop", 2'd2, 2'b00, 1'b0, 1'b1, 1'b0);
    step(); chk("t4.exit", 2'd3, 2'b11, 1'b1, 1'b0, 1'b0);
    qacceptn_i = 2'b11;
    step(); chk("t4.run",  2'd0, 2'b11, 1'b1, 1'b0, 1'b1);

    // 5: qactive wakes from STOPPED; partial release holds EXIT
    sw_sleep_req_i = 1'b1;
    step(); chk("t5.req", 2'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    sw_sleep_req_i = 1'b0;
    qacceptn_i     = 2'b00;
    step(); chk("t5.stop", 2'd2, 2'b00, 1'b0, 1'b1, 1'b0);
    step(); chk("t5.nopend", 2'd2, 2'b00, 1'b0, 1'b0, 1'b0);
    qactive_i = 2'b10;
    step(); chk("t5.exit", 2'd3, 2'b11, 1'b1, 1'b0, 1'b0);
    qactive_i  = 2'b00;
    qacceptn_i = 2'b01;
    step(); chk("t5.partial1", 2'd3, 2'b11, 1'b1, 1'b0, 1'b0);
    step(); chk("t5.partial2", 2'd3, 2'b11, 1'b1, 1'b0, 1'b0);
    qacceptn_i = 2'b11;
    step(); chk("t5.run", 2'd0, 2'b11, 1'b1, 1'b0, 1'b1);

    // 6: asynchronous reset while STOPPED
    sw_sleep_req_i = 1'b1;
    step(); chk("t6.req", 2'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    sw_sleep_req_i = 1'b0;
    qacceptn_i     = 2'b00;
    step(); chk("t6.stop", 2'd2, 2'b00, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6.async_rst", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
    qacceptn_i = 2'b11;
    step();
    reset = 1'b0;

    // 7: wake has priority over a software request; release lets it through
    wake_i         = 1'b1;
    sw_sleep_req_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(); chk("t7.wake_prio", 2'd0, 2'b11, 1'b1, 1'b0, 1'b0);
    end
    wake_i = 1'b0;
    step(); chk("t7.req", 2'd1, 2'b00, 1'b1, 1'b0, 1'b0);
    sw_sleep_req_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
